// File: rtl/div_unit_pkg.sv
// Shared RV32IM divide definitions: DivSel encodings, iteration count and
// small helpers used by the divider and the ALU decode.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIVSEL_DIV  = 2'd0,
    DIVSEL_DIVU = 2'd1,
    DIVSEL_REM  = 2'd2,
    DIVSEL_REMU = 2'd3
  } div_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 5;

  function automatic logic is_signed_op(input div_sel_e sel);
    return (sel == DIVSEL_DIV) || (sel == DIVSEL_REM);
  endfunction

  function automatic logic is_rem_op(input div_sel_e sel);
    return (sel == DIVSEL_REM) || (sel == DIVSEL_REMU);
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// 32-bit iterative divider: restoring division on magnitudes, one quotient
// bit per cycle, with combinational sign fix-up and divide-by-zero/overflow.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  DivSel,
  output logic [31:0] Result,
  output logic        busy,
  output logic        done
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dvs_q, dvs_d;
  div_sel_e         op_q, op_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [31:0]      result_q, result_d;

  div_sel_e    op_in;
  logic        sgn_in;
  logic        accept;
  logic        div_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_res;
  logic        last_iter;

  logic [32:0] shifted;
  logic [33:0] diff;
  logic        qbit;
  logic [32:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fin_res;
  logic        unused_rem_msb;

  // Capture-time decode: special cases complete in one cycle without iterating.
  always_comb begin
    op_in    = div_sel_e'(DivSel);
    sgn_in   = is_signed_op(op_in);
    accept   = start && (state_q != ST_CALC);
    div_zero = (B == 32'd0);
    overflow = sgn_in && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    special  = div_zero || overflow;
    if (div_zero) begin
      special_res = is_rem_op(op_in) ? A : 32'hFFFF_FFFF;
    end else begin
      special_res = is_rem_op(op_in) ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring step on the 33-bit shifted partial remainder.
  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    diff      = {1'b0, shifted} - {2'b00, dvs_q};
    qbit      = ~diff[33];
    rem_step  = qbit ? diff[32:0] : shifted;
    quo_step  = {quo_q[30:0], qbit};
    last_iter = (cnt_q == CNT_W'(DIV_ITERS - 1));
    quo_fix   = quo_neg_q ? (~quo_step + 32'd1) : quo_step;
    rem_fix   = rem_neg_q ? (~rem_step[31:0] + 32'd1) : rem_step[31:0];
    fin_res   = is_rem_op(op_q) ? rem_fix : quo_fix;
  end

  // The step result is always below the divisor, so its top bit is zero.
  assign unused_rem_msb = rem_step[32];

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    if (accept) begin
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = sgn_in ? abs32(A) : A;
      dvs_d     = sgn_in ? abs32(B) : B;
      op_d      = op_in;
      quo_neg_d = sgn_in && (A[31] ^ B[31]);
      rem_neg_d = sgn_in && A[31];
      if (special) begin
        result_d = special_res;
      end
    end else if (state_q == ST_CALC) begin
      cnt_d = cnt_q + CNT_W'(1);
      rem_d = rem_step[31:0];
      quo_d = quo_step;
      if (last_iter) begin
        result_d = fin_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_q      <= DIVSEL_DIV;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = special ? ST_DONE : ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_CALC);
    done = (state_q == ST_DONE);
  end

  assign Result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at issue time and
// checked against Result, latency and busy when done pulses.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  DivSel;
  logic [31:0] Result;
  logic        busy;
  logic        done;

  div_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .DivSel (DivSel),
    .Result (Result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          c0;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] hold_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Monitor: per-cycle busy/hold checks, and scoreboard pop on done.
  always @(negedge clk) begin : mon
    exp_t e;
    logic exp_busy;
    if (rst_n) begin
      exp_busy = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].lat == 33 &&
          (cyc - sb_q[0].c0) >= 1 && (cyc - sb_q[0].c0) <= 32)
        exp_busy = 1'b1;
      check_val("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (done) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val({e.tag, "_result"}, Result, e.res);
          check_val({e.tag, "_latency"}, cyc - e.c0, e.lat);
          hold_res = e.res;
        end
      end else begin
        check_val("result_hold", Result, hold_res);
        if (sb_q.size() > 0 && (cyc - sb_q[0].c0) >= sb_q[0].lat) begin
          e = sb_q.pop_front();
          check_val({e.tag, "_done_missing"}, 32'd0, 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input string tag);
    exp_t e;
    e.res = exp_res;
    e.c0  = cyc;
    e.lat = ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    e.tag = tag;
    sb_q.push_back(e);
    start  = 1'b1;
    A      = a;
    B      = b;
    DivSel = op;
    @(posedge clk);
    #1;
    start  = 1'b0;
    A      = $urandom;
    B      = $urandom;
    DivSel = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb_q.size() > 0) begin
      check_val("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    int          c0;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          seen;

    rst_n  = 1'b0;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    DivSel = '0;
    #2;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_result", Result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(2'd1, 32'd100, 32'd7, 32'd14, "divu_100_7");               drain();
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");    drain();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");    drain();
    issue(2'd3, 32'd100, 32'd7, 32'd2, "remu_100_7");                drain();
    issue(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_5_0");            drain();
    issue(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem_m5_0");    drain();
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"); drain();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");     drain();
    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "divu_nonovf"); drain();
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "remu_nonovf"); drain();
    issue(2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");    drain();
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem_7_m2");            drain();

    // Special-case ops issued back-to-back from their own DONE cycles.
    issue(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, "b2b_sp1");
    issue(2'd3, 32'd9, 32'd0, 32'd9, "b2b_sp2");
    issue(2'd1, 32'd81, 32'd9, 32'd9, "b2b_norm");
    drain();

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom;
        default: rb = 32'(-$urandom_range(1, 15));
      endcase
      issue(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d", i));
      drain();
    end

    // Start during busy is ignored; immediate restart from DONE.
    c0 = cyc;
    issue(2'd1, 32'd1000, 32'd10, 32'd100, "divu_1000_10");
    while (cyc < c0 + 5) begin @(posedge clk); #1; end
    start = 1'b1; A = 32'd9; B = 32'd3; DivSel = 2'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) check_val("b2b_wait_done", 32'd0, 32'd1);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "b2b_div");
    drain();

    // Reset mid-CALC: abort, no later done.
    c0 = cyc;
    issue(2'd1, 32'h1234_5678, 32'd3, model(2'd1, 32'h1234_5678, 32'd3), "aborted");
    while (cyc < c0 + 10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    sb_q.delete();
    hold_res = '0;
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_result", Result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "divu_max_1");
    drain();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
